// File: rtl/tetris_input_cmd_fsm.sv
// Pushbutton and gravity command source for the block move FSM.
// Issues one held changeblock code at a time and waits for doneLogic or an ack timeout.
module tetris_input_cmd_fsm #(
    parameter int GRAVITY_PERIOD = 25_000_000,
    parameter int DEBOUNCE       = 250_000,
    parameter int ACK_TIMEOUT    = 1023
) (
    input  logic       CLOCK_50,
    input  logic       Resetn,
    input  logic [1:0] mode,
    input  logic [3:0] KEY,
    input  logic       doneLogic,
    output logic [3:0] changeblock,
    output logic       dropPending,
    output logic       cmdTimeout
);

    localparam int DW = $clog2(DEBOUNCE + 1);
    localparam int GW = $clog2(GRAVITY_PERIOD);
    localparam int AW = $clog2(ACK_TIMEOUT + 1);

    typedef enum logic [3:0] {
        NOT_PLAY    = 4'd0,
        NOTHING     = 4'd1,
        DROP        = 4'd2,
        LEFT        = 4'd3,
        RIGHT       = 4'd4,
        DOWN        = 4'd5,
        ROTATE      = 4'd6,
        LEFT_WAIT   = 4'd7,
        RIGHT_WAIT  = 4'd8,
        DOWN_WAIT   = 4'd9,
        ROTATE_WAIT = 4'd10
    } state_t;

    state_t          state, next_state;
    logic [3:0]      sync1, sync2, key_level, arm, issue;
    logic [DW-1:0]   stable_cnt [4];
    logic [GW-1:0]   grav_cnt;
    logic [AW-1:0]   ack_cnt;
    logic            playing, is_cmd, ack_expired, ack, timeout_now, enter_drop, grav_wrap;
    logic [3:0]      pressed;

    assign playing     = (mode == 2'b01);
    assign pressed     = ~key_level;
    assign is_cmd      = (state == DROP) || (state == LEFT) || (state == RIGHT) ||
                         (state == DOWN) || (state == ROTATE);
    assign ack_expired = (ack_cnt == AW'(ACK_TIMEOUT - 1));
    assign ack         = doneLogic || ack_expired;
    assign timeout_now = is_cmd && !doneLogic && ack_expired;
    assign enter_drop  = (next_state == DROP) && (state != DROP);
    assign grav_wrap   = (grav_cnt == GW'(GRAVITY_PERIOD - 1));
    assign changeblock = state;

    // Keys idle high, so synchronisers and debounced levels come out of reset released.
    always_ff @(posedge CLOCK_50) begin
        if (!Resetn) begin
            sync1     <= 4'hF;
            sync2     <= 4'hF;
            key_level <= 4'hF;
            for (int i = 0; i < 4; i++) stable_cnt[i] <= '0;
        end else begin
            sync1 <= KEY;
            sync2 <= sync1;
            for (int i = 0; i < 4; i++) begin
                if (sync2[i] == key_level[i]) begin
                    stable_cnt[i] <= '0;
                end else if (stable_cnt[i] == DW'(DEBOUNCE - 1)) begin
                    key_level[i]  <= sync2[i];
                    stable_cnt[i] <= '0;
                end else begin
                    stable_cnt[i] <= stable_cnt[i] + 1'b1;
                end
            end
        end
    end

    always_ff @(posedge CLOCK_50) begin
        if (!Resetn || !playing) arm <= 4'hF;
        else                     arm <= (arm | key_level) & ~issue;
    end

    // A wrap while a drop is already pending is simply lost.
    always_ff @(posedge CLOCK_50) begin
        if (!Resetn || !playing) begin
            grav_cnt    <= '0;
            dropPending <= 1'b0;
        end else begin
            grav_cnt <= grav_wrap ? '0 : grav_cnt + 1'b1;
            if (enter_drop)     dropPending <= 1'b0;
            else if (grav_wrap) dropPending <= 1'b1;
        end
    end

    always_ff @(posedge CLOCK_50) begin
        if (!Resetn || !playing) begin
            ack_cnt    <= '0;
            cmdTimeout <= 1'b0;
        end else begin
            cmdTimeout <= timeout_now;
            ack_cnt    <= (is_cmd && next_state == state) ? ack_cnt + 1'b1 : '0;
        end
    end

    always_ff @(posedge CLOCK_50) begin
        if (!Resetn) state <= NOT_PLAY;
        else         state <= next_state;
    end

    always_comb begin
        next_state = state;
        issue      = 4'b0000;
        case (state)
            NOT_PLAY: if (playing) next_state = NOTHING;
            NOTHING: begin
                if (dropPending) begin
                    next_state = DROP;
                end else if (arm[3] && pressed[3]) begin
                    next_state = LEFT;
                    issue[3]   = 1'b1;
                end else if (arm[2] && pressed[2]) begin
                    next_state = RIGHT;
                    issue[2]   = 1'b1;
                end else if (arm[1] && pressed[1]) begin
                    next_state = DOWN;
                    issue[1]   = 1'b1;
                end else if (arm[0] && pressed[0]) begin
                    next_state = ROTATE;
                    issue[0]   = 1'b1;
                end
            end
            DROP:        if (ack) next_state = NOTHING;
            LEFT:        if (ack) next_state = LEFT_WAIT;
            RIGHT:       if (ack) next_state = RIGHT_WAIT;
            DOWN:        if (ack) next_state = DOWN_WAIT;
            ROTATE:      if (ack) next_state = ROTATE_WAIT;
            // Gravity preempts a key that is still being held down.
            LEFT_WAIT:   if (dropPending) next_state = DROP; else if (key_level[3]) next_state = NOTHING;
            RIGHT_WAIT:  if (dropPending) next_state = DROP; else if (key_level[2]) next_state = NOTHING;
            DOWN_WAIT:   if (dropPending) next_state = DROP; else if (key_level[1]) next_state = NOTHING;
            ROTATE_WAIT: if (dropPending) next_state = DROP; else if (key_level[0]) next_state = NOTHING;
            default:     next_state = NOT_PLAY;
        endcase
        if (!playing) begin
            next_state = NOT_PLAY;
            issue      = 4'b0000;
        end
    end

endmodule

// File: tb/tb_tetris_input_cmd_fsm.sv
// Scoreboard bench for tetris_input_cmd_fsm: stimulus queues expected codes, a monitor pops them.
module tb_tetris_input_cmd_fsm;

    logic       CLOCK_50 = 1'b0;
    logic       Resetn;
    logic [1:0] mode;
    logic [3:0] KEY;
    logic       doneLogic;
    logic [3:0] changeblock;
    logic       dropPending;
    logic       cmdTimeout;

    int         total_checks = 0;
    int         passed_checks = 0;
    int         timeouts_seen = 0;
    int         timeouts_expected = 0;
    logic [3:0] exp_q [$];
    logic [3:0] prev_cb;
    logic       mon_en = 1'b0;

    tetris_input_cmd_fsm #(
        .GRAVITY_PERIOD(50),
        .DEBOUNCE      (4),
        .ACK_TIMEOUT   (16)
    ) dut (
        .CLOCK_50   (CLOCK_50),
        .Resetn     (Resetn),
        .mode       (mode),
        .KEY        (KEY),
        .doneLogic  (doneLogic),
        .changeblock(changeblock),
        .dropPending(dropPending),
        .cmdTimeout (cmdTimeout)
    );

    always #5 CLOCK_50 = ~CLOCK_50;

    task automatic tick();
        @(posedge CLOCK_50);
        #1;
    endtask

    task automatic applyStimulus(input logic [1:0] m, input logic [3:0] k, input logic d);
        mode      = m;
        KEY       = k;
        doneLogic = d;
    endtask

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        total_checks++;
        if (actual === expected) passed_checks++;
        else $display("[TB] FAIL %s: got %0d, expected %0d at %0t", name, actual, expected, $time);
    endtask

    task automatic expect_code(input logic [3:0] code);
        exp_q.push_back(code);
    endtask

    // Tick until changeblock equals code; n returns ticks taken, bound expiry is a failure.
    task automatic wait_code(input string name, input logic [3:0] code, input int bound, output int n);
        n = 0;
        while (changeblock !== code && n < bound) begin
            tick();
            n++;
        end
        if (changeblock !== code) checkOutput({name, "_wait"}, changeblock, code);
    endtask

    task automatic wait_drop(input string name, input int bound, output int n);
        n = 0;
        while (dropPending !== 1'b1 && n < bound) begin
            tick();
            n++;
        end
        if (dropPending !== 1'b1) checkOutput({name, "_wait"}, dropPending, 1);
    endtask

    // Leave play and re-enter it, clearing gravity and ack timers.
    task automatic go_idle();
        applyStimulus(2'b00, 4'hF, 1'b0);
        if (changeblock != 4'd0) expect_code(4'd0);
        tick();
        checkOutput("idle_code", changeblock, 0);
        applyStimulus(2'b01, 4'hF, 1'b0);
        expect_code(4'd1);
        tick();
        checkOutput("play_code", changeblock, 1);
    endtask

    task automatic monitor_loop();
        logic [3:0] exp;
        forever begin
            @(negedge CLOCK_50);
            if (mon_en) begin
                if (cmdTimeout === 1'b1) timeouts_seen++;
                if (changeblock !== prev_cb) begin
                    if (exp_q.size() == 0) begin
                        checkOutput("unexpected_code", changeblock, prev_cb);
                    end else begin
                        exp = exp_q.pop_front();
                        checkOutput("sb_code", changeblock, exp);
                    end
                    prev_cb = changeblock;
                end
            end
        end
    endtask

    task automatic run_tests();
        int n;
        int hold;

        Resetn = 1'b0;
        applyStimulus(2'b01, 4'hF, 1'b0);
        repeat (3) tick();
        checkOutput("reset_code", changeblock, 0);
        checkOutput("reset_drop", dropPending, 0);
        checkOutput("reset_timeout", cmdTimeout, 0);
        prev_cb = changeblock;
        mon_en  = 1'b1;

        // Test 1: gravity wrap drives a Drop, acknowledged back to Nothing.
        Resetn = 1'b1;
        expect_code(4'd1);
        tick();
        checkOutput("t1_nothing", changeblock, 1);
        wait_drop("t1_drop", 60, n);
        checkOutput("t1_wrap_cycle", n, 49);
        expect_code(4'd2);
        tick();
        checkOutput("t1_drop_code", changeblock, 2);
        checkOutput("t1_drop_cleared", dropPending, 0);
        applyStimulus(2'b01, 4'hF, 1'b1);
        expect_code(4'd1);
        tick();
        applyStimulus(2'b01, 4'hF, 1'b0);
        checkOutput("t1_ack", changeblock, 1);

        // Test 2: held Left gives exactly one command, release returns to Nothing.
        go_idle();
        applyStimulus(2'b01, 4'b0111, 1'b0);
        expect_code(4'd3);
        wait_code("t2_left", 4'd3, 20, n);
        checkOutput("t2_latency", n, 7);
        applyStimulus(2'b01, 4'b0111, 1'b1);
        expect_code(4'd7);
        tick();
        applyStimulus(2'b01, 4'b0111, 1'b0);
        checkOutput("t2_leftwait", changeblock, 7);
        repeat (32) tick();
        checkOutput("t2_held", changeblock, 7);
        applyStimulus(2'b01, 4'hF, 1'b0);
        expect_code(4'd1);
        wait_code("t2_release", 4'd1, 20, n);
        checkOutput("t2_release_latency", n, 7);

        // Test 3: a two-cycle glitch is filtered out.
        go_idle();
        applyStimulus(2'b01, 4'b0111, 1'b0);
        repeat (2) tick();
        applyStimulus(2'b01, 4'hF, 1'b0);
        repeat (12) tick();
        checkOutput("t3_glitch", changeblock, 1);

        // Test 4: Right beats Down; Down needs a fresh press.
        go_idle();
        applyStimulus(2'b01, 4'b1001, 1'b0);
        expect_code(4'd4);
        wait_code("t4_right", 4'd4, 20, n);
        checkOutput("t4_latency", n, 7);
        applyStimulus(2'b01, 4'b1001, 1'b1);
        expect_code(4'd8);
        tick();
        applyStimulus(2'b01, 4'hF, 1'b0);
        checkOutput("t4_rightwait", changeblock, 8);
        expect_code(4'd1);
        wait_code("t4_release", 4'd1, 20, n);
        repeat (3) tick();
        checkOutput("t4_no_down", changeblock, 1);
        applyStimulus(2'b01, 4'b1101, 1'b0);
        expect_code(4'd5);
        wait_code("t4_down", 4'd5, 20, n);
        applyStimulus(2'b01, 4'b1101, 1'b1);
        expect_code(4'd9);
        tick();
        applyStimulus(2'b01, 4'hF, 1'b0);
        checkOutput("t4_downwait", changeblock, 9);
        expect_code(4'd1);
        wait_code("t4_release2", 4'd1, 20, n);

        // Test 5: Rotate without doneLogic times out after 16 cycles.
        go_idle();
        applyStimulus(2'b01, 4'b1110, 1'b0);
        expect_code(4'd6);
        wait_code("t5_rotate", 4'd6, 20, n);
        expect_code(4'd10);
        hold = 1;
        for (int i = 0; i < 40; i++) begin
            tick();
            if (changeblock !== 4'd6) break;
            hold++;
        end
        checkOutput("t5_hold_cycles", hold, 16);
        checkOutput("t5_rotatewait", changeblock, 10);
        checkOutput("t5_pulse_high", cmdTimeout, 1);
        timeouts_expected++;
        tick();
        checkOutput("t5_pulse_low", cmdTimeout, 0);
        applyStimulus(2'b01, 4'hF, 1'b0);
        expect_code(4'd1);
        wait_code("t5_release", 4'd1, 20, n);

        // Test 5b: doneLogic on the timeout cycle counts as ack with no pulse.
        go_idle();
        applyStimulus(2'b01, 4'b0111, 1'b0);
        expect_code(4'd3);
        wait_code("t5b_left", 4'd3, 20, n);
        repeat (15) tick();
        applyStimulus(2'b01, 4'b0111, 1'b1);
        expect_code(4'd7);
        tick();
        applyStimulus(2'b01, 4'hF, 1'b0);
        checkOutput("t5b_leftwait", changeblock, 7);
        checkOutput("t5b_no_pulse", cmdTimeout, 0);
        expect_code(4'd1);
        wait_code("t5b_release", 4'd1, 20, n);

        // Test 6: gravity preempts LeftWait; leaving play clears timers.
        go_idle();
        applyStimulus(2'b01, 4'b0111, 1'b0);
        expect_code(4'd3);
        wait_code("t6_left", 4'd3, 20, n);
        applyStimulus(2'b01, 4'b0111, 1'b1);
        expect_code(4'd7);
        tick();
        applyStimulus(2'b01, 4'b0111, 1'b0);
        wait_drop("t6_drop", 60, n);
        checkOutput("t6_wait_state", changeblock, 7);
        expect_code(4'd2);
        tick();
        checkOutput("t6_preempt", changeblock, 2);
        applyStimulus(2'b01, 4'b0111, 1'b1);
        expect_code(4'd1);
        tick();
        applyStimulus(2'b01, 4'b0111, 1'b0);
        repeat (3) tick();
        checkOutput("t6_unarmed", changeblock, 1);
        applyStimulus(2'b01, 4'hF, 1'b0);
        repeat (8) tick();
        applyStimulus(2'b01, 4'b0111, 1'b0);
        expect_code(4'd3);
        wait_code("t6_left2", 4'd3, 20, n);
        applyStimulus(2'b00, 4'hF, 1'b0);
        expect_code(4'd0);
        tick();
        checkOutput("t6_notplay", changeblock, 0);
        checkOutput("t6_drop_clear", dropPending, 0);
        checkOutput("t6_timeout_clear", cmdTimeout, 0);
        repeat (8) tick();
        applyStimulus(2'b01, 4'hF, 1'b0);
        expect_code(4'd1);
        tick();
        wait_drop("t6_regrav", 60, n);
        checkOutput("t6_grav_restart", n, 49);
        expect_code(4'd2);
        tick();
        applyStimulus(2'b01, 4'hF, 1'b1);
        expect_code(4'd1);
        tick();
        applyStimulus(2'b01, 4'hF, 1'b0);
        checkOutput("t6_ack", changeblock, 1);

        // Reset mid-command returns to NotPlay without a timeout pulse.
        applyStimulus(2'b01, 4'b1101, 1'b0);
        expect_code(4'd5);
        wait_code("rst_down", 4'd5, 20, n);
        Resetn = 1'b0;
        expect_code(4'd0);
        tick();
        checkOutput("rst_code", changeblock, 0);
        checkOutput("rst_timeout", cmdTimeout, 0);
        applyStimulus(2'b00, 4'hF, 1'b0);
        Resetn = 1'b1;
        repeat (3) tick();

        checkOutput("queue_empty", exp_q.size(), 0);
        checkOutput("timeout_count", timeouts_seen, timeouts_expected);
    endtask

    initial begin
        fork
            monitor_loop();
            run_tests();
            begin
                #400_000;
                checkOutput("watchdog", 1, 0);
            end
        join_any
        $display("%0d/%0d checks passed", passed_checks, total_checks);
        $finish;
    end

endmodule
